// File: rtl/instruction_fetch.sv
// Fetch stage: holds the PC, fetches 32-bit words over a req/ready handshake and applies next-PC select.
// Optional build macro IF_MISALIGN_TRAP_EN turns misaligned jump targets into a sticky fault + halt.
module instruction_fetch #(
    parameter int                    ADDR_WIDTH = 64,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = {ADDR_WIDTH{1'b0}}
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_ready,
    input  logic [31:0]           imem_rdata,
    output logic [31:0]           I,
    output logic                  I_valid,
    input  logic                  stall,
    input  logic [1:0]            pc_sel,
    input  logic [ADDR_WIDTH-1:0] branch_offset,
    input  logic [ADDR_WIDTH-1:0] reg_target,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic                  halted,
    output logic                  fault
);

    localparam logic [1:0] S_WAIT  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_HALT  = 2'd2;

    localparam logic [ADDR_WIDTH-1:0] PC_STEP    = ADDR_WIDTH'(3'd4);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(2'b11);

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [31:0]           i_q, i_d;
    logic                  halted_q, halted_d;
    logic [ADDR_WIDTH-1:0] target_s;
`ifdef IF_MISALIGN_TRAP_EN
    logic                  fault_q, fault_d;
`endif

    // Candidate next PC for the instruction being issued; sums wrap modulo 2^ADDR_WIDTH.
    always_comb begin
        case (pc_sel)
            2'b01:   target_s = pc_q + (branch_offset << 2);
            2'b10:   target_s = reg_target;
            default: target_s = pc_q + PC_STEP;
        endcase
    end

    // Next-state logic for the WAIT / ISSUE / HALT sequencer.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        i_d      = i_q;
        halted_d = halted_q;
`ifdef IF_MISALIGN_TRAP_EN
        fault_d  = fault_q;
`endif
        case (state_q)
            S_WAIT: begin
                if (imem_ready) begin
                    i_d     = imem_rdata;
                    state_d = S_ISSUE;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_ISSUE: begin
                if (stall) begin
                    state_d = S_ISSUE;
                end else if (pc_sel == 2'b11) begin
                    halted_d = 1'b1;
                    state_d  = S_HALT;
`ifdef IF_MISALIGN_TRAP_EN
                end else if (target_s[1:0] != 2'b00) begin
                    // pc stays on the faulting instruction so software can locate it
                    fault_d  = 1'b1;
                    halted_d = 1'b1;
                    state_d  = S_HALT;
                end else begin
                    pc_d    = target_s;
                    state_d = S_WAIT;
                end
`else
                end else begin
                    pc_d    = target_s & ALIGN_MASK;
                    state_d = S_WAIT;
                end
`endif
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_WAIT;
            end
        endcase
    end

    // State registers; reset abandons any in-flight request.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= S_WAIT;
            pc_q     <= RESET_PC;
            i_q      <= 32'h0000_0000;
            halted_q <= 1'b0;
`ifdef IF_MISALIGN_TRAP_EN
            fault_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            i_q      <= i_d;
            halted_q <= halted_d;
`ifdef IF_MISALIGN_TRAP_EN
            fault_q  <= fault_d;
`endif
        end
    end

    // Request drops the instant reset is raised, not at the next edge.
    assign imem_req  = (state_q == S_WAIT) && !reset;
    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign I         = i_q;
    assign I_valid   = (state_q == S_ISSUE);
    assign halted    = halted_q;
`ifdef IF_MISALIGN_TRAP_EN
    assign fault     = fault_q;
`else
    assign fault     = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios plus randomized traffic against a behavioural model.
module tb_instruction_fetch;

    logic        clock = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] I;
    logic        I_valid;
    logic        stall;
    logic [1:0]  pc_sel;
    logic [63:0] branch_offset;
    logic [63:0] reg_target;
    logic [63:0] pc;
    logic        halted;
    logic        fault;

    int n_checks = 0;
    int n_errors = 0;

    // model: address, held word, whether a word is held, halted
    logic [63:0] m_pc;
    logic [31:0] m_I;
    bit          m_have;
    bit          m_halt;

    instruction_fetch #(.ADDR_WIDTH(64), .RESET_PC(64'h0)) dut (
        .clock(clock), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .I(I), .I_valid(I_valid), .stall(stall), .pc_sel(pc_sel),
        .branch_offset(branch_offset), .reg_target(reg_target),
        .pc(pc), .halted(halted), .fault(fault)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 64'h0; m_I = 32'h0; m_have = 1'b0; m_halt = 1'b0;
    endtask

    // Advances the model by one clock edge from the inputs the bench is driving.
    task automatic model_edge();
        if (reset) begin
            model_reset();
        end else if (m_halt) begin
            m_halt = 1'b1;
        end else if (!m_have) begin
            if (imem_ready) begin
                m_I = imem_rdata;
                m_have = 1'b1;
            end
        end else if (!stall) begin
            m_have = 1'b0;
            case (pc_sel)
                2'd0: m_pc = m_pc + 64'd4;
                2'd1: m_pc = m_pc + branch_offset * 64'd4;
                2'd2: m_pc = reg_target - (reg_target % 64'd4);
                default: m_halt = 1'b1;
            endcase
        end
    endtask

    task automatic check_model();
        chk("imem_req", {63'h0, imem_req}, {63'h0, (!reset && !m_have && !m_halt)});
        chk("imem_addr", imem_addr, m_pc);
        chk("pc", pc, m_pc);
        chk("I", {32'h0, I}, {32'h0, m_I});
        chk("I_valid", {63'h0, I_valid}, {63'h0, m_have});
        chk("halted", {63'h0, halted}, {63'h0, m_halt});
        chk("fault", {63'h0, fault}, 64'h0);
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
        check_model();
    endtask

    task automatic drive(input bit rdy, input logic [31:0] rd, input bit stl,
                         input logic [1:0] sel, input logic [63:0] off, input logic [63:0] tgt);
        imem_ready = rdy; imem_rdata = rd; stall = stl;
        pc_sel = sel; branch_offset = off; reg_target = tgt;
    endtask

    initial begin
        int halt_cycles;
        reset = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 2'd0, 64'h0, 64'h0);
        model_reset();
        step();
        step();
        chk("reset_req", {63'h0, imem_req}, 64'h0);
        chk("reset_pc", pc, 64'h0);
        chk("reset_valid", {63'h0, I_valid}, 64'h0);
        reset = 1'b0;
        #1;
        check_model();
        chk("first_req", {63'h0, imem_req}, 64'h1);

        // two sequential words, memory always ready
        drive(1'b1, 32'h9100_0821, 1'b0, 2'd0, 64'h0, 64'h0);
        step();
        chk("seq_I0", {32'h0, I}, 64'h9100_0821);
        chk("seq_pc0", pc, 64'h0);
        chk("seq_req_off", {63'h0, imem_req}, 64'h0);
        imem_rdata = 32'hCB01_0000;
        step();
        chk("seq_addr1", imem_addr, 64'h4);
        step();
        chk("seq_I1", {32'h0, I}, 64'hCB01_0000);
        chk("seq_pc1", pc, 64'h4);

        // issue to 0x10, memory delayed 3 cycles
        drive(1'b0, 32'h1111_2222, 1'b0, 2'd2, 64'h0, 64'h10);
        step();
        for (int k = 0; k < 3; k++) begin
            step();
            chk("delay_req", {63'h0, imem_req}, 64'h1);
            chk("delay_addr", imem_addr, 64'h10);
        end
        imem_ready = 1'b1;
        step();
        chk("delay_valid", {63'h0, I_valid}, 64'h1);

        // branch backward by two words
        drive(1'b0, 32'h3333_4444, 1'b0, 2'd1, 64'hFFFF_FFFF_FFFF_FFFE, 64'h0);
        step();
        chk("branch_addr", imem_addr, 64'h8);
        imem_ready = 1'b1;
        step();

        // misaligned register target is silently aligned
        drive(1'b1, 32'h5555_6666, 1'b0, 2'd2, 64'h0, 64'h103);
        step();
        chk("reg_align", imem_addr, 64'h100);
        step();

        // wrap at the top of the address space
        drive(1'b1, 32'h7777_8888, 1'b0, 2'd2, 64'h0, 64'hFFFF_FFFF_FFFF_FFFC);
        step();
        chk("wrap_top", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        step();
        pc_sel = 2'd0;
        step();
        chk("wrap_zero", imem_addr, 64'h0);
        imem_rdata = 32'hABCD_EF01;
        step();

        // stall holds everything while pc_sel toggles
        stall = 1'b1;
        for (int k = 0; k < 5; k++) begin
            pc_sel = 2'($urandom_range(0, 3));
            branch_offset = 64'($urandom);
            step();
            chk("stall_I", {32'h0, I}, 64'hABCD_EF01);
            chk("stall_pc", pc, 64'h0);
            chk("stall_valid", {63'h0, I_valid}, 64'h1);
        end
        drive(1'b0, 32'h0, 1'b0, 2'd1, 64'h3, 64'h0);
        step();
        chk("stall_release", imem_addr, 64'hC);

        // reset in the middle of WAIT, then halt
        step();
        reset = 1'b1;
        #1;
        chk("midreset_req", {63'h0, imem_req}, 64'h0);
        chk("midreset_pc", pc, 64'h0);
        model_reset();
        step();
        reset = 1'b0;
        #1;
        check_model();
        drive(1'b1, 32'h0BAD_F00D, 1'b0, 2'd3, 64'h0, 64'h0);
        step();
        step();
        chk("halt_flag", {63'h0, halted}, 64'h1);
        for (int k = 0; k < 10; k++) begin
            imem_ready = 1'($urandom);
            step();
            chk("halt_noreq", {63'h0, imem_req}, 64'h0);
        end

        // randomized traffic
        halt_cycles = 0;
        for (int k = 0; k < 3000; k++) begin
            reset = (m_halt && halt_cycles > 3) || ($urandom_range(0, 299) == 0);
            if (reset) halt_cycles = 0;
            imem_ready = ($urandom_range(0, 2) != 0);
            imem_rdata = $urandom;
            stall = ($urandom_range(0, 9) < 3);
            pc_sel = ($urandom_range(0, 19) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            branch_offset = ($urandom_range(0, 3) == 0) ? {32'($urandom), 32'($urandom)}
                                                         : 64'($signed(32'($urandom_range(0, 64)) - 32'd32));
            case ($urandom_range(0, 2))
                0: reg_target = {32'($urandom), 32'($urandom)};
                1: reg_target = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
                default: reg_target = 64'($urandom_range(0, 255));
            endcase
            step();
            if (m_halt) halt_cycles++;
        end
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
